bus_arbiter: RTL and testbench

Parametrised N-master bus arbiter that replaces the hard-wired CPU/DMA bus mux in the top level. Each master raises a request. The arbiter registers a one-hot grant and steers the winner's address, write data and strobes onto the shared slave bus, where the slave read data is OR-combined. Two arbitration modes are supported: fixed-priority and round-robin. A master can hold the bus for a burst using lock, and a hold limit guarantees that a locked master cannot starve the others.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/rr_pick.sv | 51 +++++
 rtl/bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the bus arbiter: arbitration mode
//                encodings, default bus widths and the owner-index width
//                helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

   localparam int MODE_FIXED = 0;
   localparam int MODE_RR    = 1;

   localparam int DEFAULT_AW = 16;
   localparam int DEFAULT_DW = 8;

   // Width of an owner index; never below one bit so a two-master bus still
   // gets a real port.
   function automatic int owner_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational priority picker. Scans the request vector
//                starting at index 'start', wrapping modulo N, skipping any
//                bit set in 'mask'. Reports the first eligible index.
//  Ports       : req    - request vector
//                start  - first index examined
//                mask   - requests to ignore
//                winner - index of the chosen requester (0 when none)
//                found  - a requester was chosen
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   input  logic [N-1:0]  mask,
   output logic [IW-1:0] winner,
   output logic          found
);

   logic [N-1:0] w_elig;
   logic [N-1:0] w_shift;
   int           w_idx;

   assign w_elig = req & ~mask;

   always_comb begin
      winner  = '0;
      found   = 1'b0;
      w_idx   = 0;
      w_shift = '0;
      for (int k = 0; k < N; k++) begin
         // start is always < N, so a single subtraction performs the wrap
         w_idx = int'(start) + k;
         if (w_idx >= N) begin
            w_idx = w_idx - N;
         end
         w_shift = w_elig >> w_idx;
         if (!found && w_shift[0]) begin
            found  = 1'b1;
            winner = IW'(w_idx);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : N-master shared-bus arbiter with registered one-hot grant,
//                fixed-priority or round-robin selection, lock-based bursts
//                and a hold limit that bounds a locked tenure whenever
//                another master is waiting.
//  Ports       : clock, reset           - bus clock, async active-high reset
//                m_req/m_lock           - per-master request / keep-ownership
//                m_address/m_outdata    - packed per-master address / wdata
//                m_load/m_store         - per-master read / write strobes
//                m_grant                - registered one-hot grant
//                m_indata               - read data broadcast to masters
//                bus_address/outdata    - steered slave address / wdata
//                bus_load/bus_store     - steered slave strobes
//                bus_data               - OR-combined slave read data
//                bus_owner              - current owner index
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MASTERS  = 2,
   parameter int AW       = DEFAULT_AW,
   parameter int DW       = DEFAULT_DW,
   parameter int MODE     = MODE_FIXED,
   parameter int MAX_HOLD = 160
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic [MASTERS-1:0]                   m_req,
   input  logic [MASTERS-1:0]                   m_lock,
   input  logic [MASTERS*AW-1:0]                m_address,
   input  logic [MASTERS*DW-1:0]                m_outdata,
   input  logic [MASTERS-1:0]                   m_load,
   input  logic [MASTERS-1:0]                   m_store,
   output logic [MASTERS-1:0]                   m_grant,
   output logic [DW-1:0]                        m_indata,
   output logic [AW-1:0]                        bus_address,
   output logic [DW-1:0]                        bus_outdata,
   output logic                                 bus_load,
   output logic                                 bus_store,
   input  logic [DW-1:0]                        bus_data,
   output logic [owner_width(MASTERS)-1:0]      bus_owner
);

   localparam int OW = owner_width(MASTERS);
   localparam int HW = $clog2(MAX_HOLD + 1);

   localparam logic [HW-1:0]      c_hold_last = HW'(MAX_HOLD - 1);
   localparam logic [OW-1:0]      c_last_idx  = OW'(MASTERS - 1);
   localparam logic [MASTERS-1:0] c_one       = MASTERS'(1);

   logic [OW-1:0] r_owner, w_owner_nxt;
   logic          r_valid, w_valid_nxt;
   logic [HW-1:0] r_hold,  w_hold_nxt;
   logic [OW-1:0] r_ptr,   w_ptr_nxt;

   logic [MASTERS-1:0] w_owner_oh;
   logic [MASTERS-1:0] w_others;
   logic [MASTERS-1:0] w_mask;
   logic               w_hold_hit;
   logic               w_retain;
   logic [OW-1:0]      w_start;
   logic [OW-1:0]      w_winner;
   logic               w_found;

   logic [AW-1:0] w_addr_arr [MASTERS];
   logic [DW-1:0] w_data_arr [MASTERS];

   for (genvar i = 0; i < MASTERS; i++) begin : g_unpack
      assign w_addr_arr[i] = m_address[i*AW +: AW];
      assign w_data_arr[i] = m_outdata[i*DW +: DW];
   end

   assign w_owner_oh = c_one << r_owner;
   assign w_others   = m_req & ~w_owner_oh;

   // The limit only bites when someone else is waiting; an uncontested
   // locked owner sits at the saturated count and keeps the bus.
   assign w_hold_hit = r_valid && (r_hold == c_hold_last) && (|w_others);
   assign w_retain   = r_valid && m_req[r_owner] && m_lock[r_owner] && !w_hold_hit;
   assign w_mask     = w_hold_hit ? w_owner_oh : '0;

   if (MODE == MODE_RR) begin : g_rr_start
      // Search begins just after the last owner, so an unlocked owner only
      // wins again when nobody else is requesting.
      assign w_start = (r_ptr == c_last_idx) ? '0 : r_ptr + 1'b1;
   end else begin : g_fixed_start
      assign w_start = '0;
   end

   rr_pick #(
      .N  (MASTERS),
      .IW (OW)
   ) u_pick (
      .req    (m_req),
      .start  (w_start),
      .mask   (w_mask),
      .winner (w_winner),
      .found  (w_found)
   );

   always_comb begin
      w_owner_nxt = r_owner;
      w_valid_nxt = 1'b0;
      w_hold_nxt  = '0;
      w_ptr_nxt   = r_ptr;
      if (w_retain) begin
         w_valid_nxt = 1'b1;
         w_hold_nxt  = (r_hold == c_hold_last) ? r_hold : r_hold + 1'b1;
      end else if (w_found) begin
         w_owner_nxt = w_winner;
         w_valid_nxt = 1'b1;
         w_ptr_nxt   = w_winner;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_owner <= '0;
         r_valid <= 1'b0;
         r_hold  <= '0;
         r_ptr   <= '0;
      end else begin
         r_owner <= w_owner_nxt;
         r_valid <= w_valid_nxt;
         r_hold  <= w_hold_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   assign m_grant     = r_valid ? w_owner_oh : '0;
   assign bus_owner   = r_owner;
   assign bus_address = r_valid ? w_addr_arr[r_owner] : '0;
   assign bus_outdata = r_valid ? w_data_arr[r_owner] : '0;
   assign bus_load    = r_valid & m_load[r_owner];
   assign bus_store   = r_valid & m_store[r_owner];
   assign m_indata    = bus_data;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench. Instance A: 2 masters, fixed priority,
//                MAX_HOLD = 4. Instance B: 3 masters, round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;
   import bus_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // ---------------- instance A ----------------
   logic [1:0]  a_req = '0, a_lock = '0, a_load = '0, a_store = '0;
   logic [31:0] a_addr = {16'hC000, 16'h1000};
   logic [15:0] a_wd   = {8'hA5, 8'h11};
   logic [7:0]  a_bd   = '0;
   logic [1:0]  a_grant;
   logic [7:0]  a_indata, a_bwd;
   logic [15:0] a_baddr;
   logic        a_bload, a_bstore;
   logic [0:0]  a_owner;

   bus_arbiter #(.MASTERS(2), .AW(16), .DW(8), .MODE(MODE_FIXED), .MAX_HOLD(4)) u_dut_a (
      .clock(clock), .reset(reset), .m_req(a_req), .m_lock(a_lock),
      .m_address(a_addr), .m_outdata(a_wd), .m_load(a_load), .m_store(a_store),
      .m_grant(a_grant), .m_indata(a_indata), .bus_address(a_baddr),
      .bus_outdata(a_bwd), .bus_load(a_bload), .bus_store(a_bstore),
      .bus_data(a_bd), .bus_owner(a_owner));

   // ---------------- instance B ----------------
   logic [2:0]  b_req = '0, b_lock = '0, b_load = '0, b_store = '0;
   logic [47:0] b_addr = {16'h2002, 16'h2001, 16'h2000};
   logic [23:0] b_wd   = {8'h32, 8'h31, 8'h30};
   logic [7:0]  b_bd   = '0;
   logic [2:0]  b_grant;
   logic [7:0]  b_indata, b_bwd;
   logic [15:0] b_baddr;
   logic        b_bload, b_bstore;
   logic [1:0]  b_owner;

   bus_arbiter #(.MASTERS(3), .AW(16), .DW(8), .MODE(MODE_RR), .MAX_HOLD(4)) u_dut_b (
      .clock(clock), .reset(reset), .m_req(b_req), .m_lock(b_lock),
      .m_address(b_addr), .m_outdata(b_wd), .m_load(b_load), .m_store(b_store),
      .m_grant(b_grant), .m_indata(b_indata), .bus_address(b_baddr),
      .bus_outdata(b_bwd), .bus_load(b_bload), .bus_store(b_bstore),
      .bus_data(b_bd), .bus_owner(b_owner));

   // ---------------- scoreboard ----------------
   typedef struct { string name; logic [47:0] v; } sb_t;
   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_err = 0;

   int a_mo = 0;   // model of A's owner index
   int b_mo = 0;   // model of B's owner index

   function automatic logic [47:0] pk(logic [2:0] g, logic [1:0] o, logic [15:0] ad,
                                      logic [7:0] wd, logic ld, logic st, logic [7:0] ind);
      return {9'd0, g, o, ad, wd, ld, st, ind};
   endfunction

   function automatic logic [47:0] act_a();
      return pk({1'b0, a_grant}, {1'b0, a_owner}, a_baddr, a_bwd, a_bload, a_bstore, a_indata);
   endfunction

   function automatic logic [47:0] act_b();
      return pk(b_grant, b_owner, b_baddr, b_bwd, b_bload, b_bstore, b_indata);
   endfunction

   task automatic push_exp(string nm, logic [47:0] v);
      sb_t e;
      e.name = nm;
      e.v    = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(logic [47:0] got);
      sb_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL scoreboard_empty got=%h required=<entry>", got);
      end else begin
         e = sb_q.pop_front();
         if (got !== e.v) begin
            n_err++;
            $display("FAIL %s got=%h required=%h", e.name, got, e.v);
         end
      end
   endtask

   // Expected outputs of A for grant g with the inputs as currently driven.
   function automatic logic [47:0] exp_a(logic [1:0] g);
      if (g == 2'b00)
         return pk(3'b0, 2'(a_mo), 16'h0, 8'h0, 1'b0, 1'b0, a_bd);
      return pk({1'b0, g}, 2'(a_mo), a_addr[a_mo*16 +: 16], a_wd[a_mo*8 +: 8],
                a_load[a_mo], a_store[a_mo], a_bd);
   endfunction

   function automatic logic [47:0] exp_b(logic [2:0] g);
      if (g == 3'b000)
         return pk(3'b0, 2'(b_mo), 16'h0, 8'h0, 1'b0, 1'b0, b_bd);
      return pk(g, 2'(b_mo), b_addr[b_mo*16 +: 16], b_wd[b_mo*8 +: 8],
                b_load[b_mo], b_store[b_mo], b_bd);
   endfunction

   // Drive A's inputs, queue the expectation for after the next edge, check it.
   task automatic step_a(string nm, logic [1:0] req, logic [1:0] lock,
                         logic [1:0] ld, logic [1:0] st, logic [1:0] g);
      a_req = req; a_lock = lock; a_load = ld; a_store = st;
      a_bd  = 8'($urandom);
      if (g != 2'b00) a_mo = g[1] ? 1 : 0;
      push_exp(nm, exp_a(g));
      @(posedge clock);
      #1;
      pop_check(act_a());
   endtask

   task automatic step_b(string nm, logic [2:0] req, logic [2:0] g);
      b_req = req; b_lock = '0; b_load = 3'b000; b_store = 3'b000;
      b_bd  = 8'($urandom);
      if (g != 3'b000) b_mo = g[2] ? 2 : (g[1] ? 1 : 0);
      push_exp(nm, exp_b(g));
      @(posedge clock);
      #1;
      pop_check(act_b());
   endtask

   typedef struct {
      string      name;
      logic [1:0] req, lock, ld, st, g;
   } vec_t;
   vec_t va [16];

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      va[0]  = '{"rst_release", 2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
      va[1]  = '{"prio_hold1",  2'b11, 2'b00, 2'b01, 2'b00, 2'b01};
      va[2]  = '{"prio_hold2",  2'b11, 2'b00, 2'b00, 2'b00, 2'b01};
      va[3]  = '{"prio_switch", 2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
      va[4]  = '{"gate_st1",    2'b11, 2'b00, 2'b00, 2'b10, 2'b01};
      va[5]  = '{"gate_st0",    2'b11, 2'b00, 2'b00, 2'b11, 2'b01};
      va[6]  = '{"write_m1",    2'b10, 2'b00, 2'b00, 2'b10, 2'b10};
      va[7]  = '{"idle",        2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      va[8]  = '{"rel_a",       2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
      va[9]  = '{"rel_nodead",  2'b10, 2'b00, 2'b00, 2'b00, 2'b10};
      va[10] = '{"idle2",       2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      va[11] = '{"lock_c1",     2'b10, 2'b10, 2'b00, 2'b00, 2'b10};
      va[12] = '{"lock_c2",     2'b11, 2'b10, 2'b00, 2'b00, 2'b10};
      va[13] = '{"lock_c3",     2'b11, 2'b10, 2'b00, 2'b00, 2'b10};
      va[14] = '{"lock_c4",     2'b11, 2'b10, 2'b00, 2'b00, 2'b10};
      va[15] = '{"hold_limit",  2'b11, 2'b10, 2'b00, 2'b00, 2'b01};

      // Reset with both masters requesting: everything idle.
      reset = 1'b1;
      a_req = 2'b11;
      a_bd  = 8'h5C;
      a_mo  = 0;
      @(posedge clock);
      #1;
      push_exp("reset_state", exp_a(2'b00));
      pop_check(act_a());
      reset = 1'b0;

      foreach (va[i])
         step_a(va[i].name, va[i].req, va[i].lock, va[i].ld, va[i].st, va[i].g);

      // Uncontested lock holds far beyond MAX_HOLD, then yields at once
      // when a competitor appears with the counter already saturated.
      step_a("long_idle", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      for (int i = 0; i < 25; i++)
         step_a("long_hold", 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
      step_a("sat_switch", 2'b11, 2'b10, 2'b00, 2'b00, 2'b01);

      // Reset in the middle of a locked burst.
      step_a("burst1", 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
      step_a("burst2", 2'b10, 2'b10, 2'b00, 2'b00, 2'b10);
      #2;
      reset = 1'b1;
      a_mo  = 0;
      #1;
      push_exp("reset_async", exp_a(2'b00));
      pop_check(act_a());
      a_req  = 2'b11;
      a_lock = 2'b11;
      @(posedge clock);
      #1;
      push_exp("reset_held", exp_a(2'b00));
      pop_check(act_a());
      reset = 1'b0;
      step_a("reset_regrant", 2'b11, 2'b11, 2'b00, 2'b00, 2'b01);
      a_req  = 2'b00;
      a_lock = 2'b00;

      // Round-robin on instance B: park the pointer on master 2 first.
      reset = 1'b1;
      b_mo  = 0;
      @(posedge clock);
      #1;
      push_exp("b_reset", exp_b(3'b000));
      pop_check(act_b());
      reset = 1'b0;
      step_b("rr_park", 3'b100, 3'b100);
      step_b("rr_0",    3'b111, 3'b001);
      step_b("rr_1",    3'b111, 3'b010);
      step_b("rr_2",    3'b111, 3'b100);
      step_b("rr_wrap", 3'b111, 3'b001);
      step_b("rr_solo", 3'b001, 3'b001);
      step_b("rr_idle", 3'b000, 3'b000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
